// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadow/active digit banks, blanked slots, shared registered decoder.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic                          commit,
  output logic                          commit_pending,
  output logic                          frame_done,
  output logic [3:0]                    dec_data,
  output logic [NUM_DIGITS-1:0]         digit_sel
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  logic [1:0]    state, nextState;
  logic [AW-1:0] idx, nextIdx;
  logic [CW-1:0] cnt, nextCnt;
  logic          frameStart, wrap, slotStart, driveOk;
  logic [3:0]    shadow [NUM_DIGITS];
  logic [3:0]    active [NUM_DIGITS];

  always_comb begin
    nextState  = state;
    nextIdx    = idx;
    nextCnt    = cnt + CW'(1);
    frameStart = 1'b0;
    wrap       = 1'b0;
    slotStart  = 1'b0;
    if (!enable) begin
      nextState = IDLE;
      nextIdx   = '0;
      nextCnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nextState  = BLANK;
          nextIdx    = '0;
          nextCnt    = '0;
          frameStart = 1'b1;
          slotStart  = 1'b1;
        end
        BLANK: begin
          if (cnt == CW'(BLANK_CYC - 1)) nextState = DRIVE;
        end
        DRIVE: begin
          if (cnt == CW'(SCAN_DIV - 1)) begin
            nextState = BLANK;
            nextCnt   = '0;
            slotStart = 1'b1;
            if (idx == AW'(NUM_DIGITS - 1)) begin
              nextIdx    = '0;
              frameStart = 1'b1;
              wrap       = 1'b1;
            end else begin
              nextIdx = idx + AW'(1);
            end
          end
        end
        default: begin
          nextState = IDLE;
          nextIdx   = '0;
          nextCnt   = '0;
        end
      endcase
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Digits above the most significant nonzero active digit stay dark; digit 0 always lights.
  logic [AW-1:0] highIdx;
  always_comb begin
    highIdx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (active[i] != 4'd0) highIdx = AW'(i);
    driveOk = (nextIdx <= highIdx);
  end
`else
  assign driveOk = 1'b1;
`endif

  // The slot's digit is latched as the slot is entered, forwarding the bank copy at a frame start,
  // so the decoder output has settled by the time the digit enable rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      frame_done     <= 1'b0;
      commit_pending <= 1'b0;
      dec_data       <= 4'd0;
      digit_sel      <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= 4'd0;
        active[i] <= 4'd0;
      end
    end else begin
      state      <= nextState;
      idx        <= nextIdx;
      cnt        <= nextCnt;
      frame_done <= wrap;
      if (wr_en && (int'(wr_addr) < NUM_DIGITS)) shadow[wr_addr] <= wr_data;
      if (frameStart && commit_pending) begin
        active         <= shadow;
        commit_pending <= commit;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
      if (slotStart)
        dec_data <= (frameStart && commit_pending) ? shadow[nextIdx] : active[nextIdx];
      if (nextState == DRIVE && driveOk)
        digit_sel <= NUM_DIGITS'(1) << nextIdx;
      else
        digit_sel <= '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with 4 digits, 8-clock slots and 2 blank clocks.
module tb_seg_scan_ctrl;

`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic       frame_done;
  logic [3:0] dec_data;
  logic [3:0] digit_sel;

  int checks = 0;
  int fails  = 0;
  int cyc    = -1;

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .commit_pending(commit_pending),
    .frame_done(frame_done), .dec_data(dec_data), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic       we;
    logic [1:0] addr;
    logic [3:0] data;
    logic       cm;
    logic [3:0] expDec;
    logic [3:0] expSel;
    logic       expPend;
    logic       expFd;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    if (cyc > target) begin
      checks++;
      fails++;
      $display("[TB] FAIL runTo: at cycle %0d, required cycle %0d", cyc, target);
    end
    while (cyc < target) tick();
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [3:0] data,
                               input logic cm);
    wr_en   = we;
    wr_addr = addr;
    wr_data = data;
    commit  = cm;
    tick();
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic [3:0] d, input logic [3:0] s,
                          input logic p, input logic f);
    checkOutput({name, ".dec_data"}, {4'd0, dec_data}, {4'd0, d});
    checkOutput({name, ".digit_sel"}, {4'd0, digit_sel}, {4'd0, s});
    checkOutput({name, ".commit_pending"}, {7'd0, commit_pending}, {7'd0, p});
    checkOutput({name, ".frame_done"}, {7'd0, frame_done}, {7'd0, f});
  endtask

  initial begin
    vecs[0]  = '{0,  1'b0, 2'd0, 4'd0, 1'b0, 4'd1, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{1,  1'b0, 2'd0, 4'd0, 1'b0, 4'd1, 4'b0000, 1'b0, 1'b0};
    vecs[2]  = '{2,  1'b0, 2'd0, 4'd0, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0};
    vecs[3]  = '{7,  1'b0, 2'd0, 4'd0, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0};
    vecs[4]  = '{8,  1'b0, 2'd0, 4'd0, 1'b0, 4'd2, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{10, 1'b0, 2'd0, 4'd0, 1'b0, 4'd2, 4'b0010, 1'b0, 1'b0};
    vecs[6]  = '{15, 1'b0, 2'd0, 4'd0, 1'b0, 4'd2, 4'b0010, 1'b0, 1'b0};
    vecs[7]  = '{16, 1'b0, 2'd0, 4'd0, 1'b0, 4'd3, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{18, 1'b0, 2'd0, 4'd0, 1'b0, 4'd3, 4'b0100, 1'b0, 1'b0};
    vecs[9]  = '{23, 1'b0, 2'd0, 4'd0, 1'b0, 4'd3, 4'b0100, 1'b0, 1'b0};
    vecs[10] = '{24, 1'b0, 2'd0, 4'd0, 1'b0, 4'd4, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{26, 1'b0, 2'd0, 4'd0, 1'b0, 4'd4, 4'b1000, 1'b0, 1'b0};
    vecs[12] = '{31, 1'b0, 2'd0, 4'd0, 1'b0, 4'd4, 4'b1000, 1'b0, 1'b0};
    vecs[13] = '{32, 1'b0, 2'd0, 4'd0, 1'b0, 4'd1, 4'b0000, 1'b0, 1'b1};
    vecs[14] = '{33, 1'b0, 2'd0, 4'd0, 1'b0, 4'd1, 4'b0000, 1'b0, 1'b0};
    vecs[15] = '{34, 1'b1, 2'd0, 4'd9, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0};

    reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0; commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset", 4'd0, 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Load the shadow bank and request a commit while dark.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 4'(i + 1), 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkAll("pre_enable", 4'd0, 4'b0000, 1'b1, 1'b0);

    enable = 1'b1;
    cyc = -1;
    foreach (vecs[i]) begin
      runTo(vecs[i].k);
      checkAll($sformatf("scan_k%0d", vecs[i].k), vecs[i].expDec, vecs[i].expSel,
               vecs[i].expPend, vecs[i].expFd);
      if (vecs[i].we || vecs[i].cm)
        applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].cm);
    end

    // Uncommitted write must not reach the display; a later commit lands at the wrap.
    runTo(64);
    checkAll("tear_free_hold", 4'd1, 4'b0000, 1'b0, 1'b1);
    runTo(80);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkOutput("pending_set", {7'd0, commit_pending}, 8'd1);
    runTo(95);
    checkOutput("pending_hold", {7'd0, commit_pending}, 8'd1);
    runTo(96);
    checkAll("commit_applied", 4'd9, 4'b0000, 1'b0, 1'b1);

    // Write on the wrap cycle with a commit pending: the copy takes the old shadow value.
    runTo(100);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    runTo(127);
    checkOutput("pending_before_wrap", {7'd0, commit_pending}, 8'd1);
    applyStimulus(1'b1, 2'd3, 4'd7, 1'b0);
    checkAll("wrap_copy", 4'd9, 4'b0000, 1'b0, 1'b1);
    runTo(152);
    checkOutput("slot3_old_value", {4'd0, dec_data}, 8'd4);
    runTo(184);
    checkOutput("slot3_still_old", {4'd0, dec_data}, 8'd4);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    runTo(216);
    checkOutput("slot3_new_value", {4'd0, dec_data}, 8'd7);

    // Enable drop mid-DRIVE, then restart with a pending commit.
    runTo(244);
    checkOutput("before_drop", {4'd0, digit_sel}, 8'b0100);
    enable = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkAll("dropped", 4'd3, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 4'd6, 1'b0);
    runTo(248);
    enable = 1'b1;
    tick();
    checkAll("restart", 4'd6, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("restart_blank2", {4'd0, digit_sel}, 8'b0000);
    tick();
    checkOutput("restart_drive", {4'd0, digit_sel}, 8'b0001);

    // Active 0,5,0,0 from the frame starting at 281.
    applyStimulus(1'b1, 2'd0, 4'd0, 1'b0);
    applyStimulus(1'b1, 2'd1, 4'd5, 1'b0);
    applyStimulus(1'b1, 2'd2, 4'd0, 1'b0);
    applyStimulus(1'b1, 2'd3, 4'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    runTo(283);
    checkAll("lzb_slot0", 4'd0, 4'b0001, 1'b0, 1'b0);
    runTo(291);
    checkAll("lzb_slot1", 4'd5, 4'b0010, 1'b0, 1'b0);
    runTo(299);
    checkOutput("lzb_slot2", {4'd0, digit_sel}, LZB ? 8'b0000 : 8'b0100);
    runTo(307);
    checkOutput("lzb_slot3", {4'd0, digit_sel}, LZB ? 8'b0000 : 8'b1000);

    // All-zero active from the frame starting at 313.
    applyStimulus(1'b1, 2'd1, 4'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    runTo(315);
    checkOutput("zero_slot0", {4'd0, digit_sel}, 8'b0001);
    runTo(323);
    checkAll("zero_slot1", 4'd0, LZB ? 4'b0000 : 4'b0010, 1'b0, 1'b0);
    runTo(339);
    checkOutput("zero_slot3", {4'd0, digit_sel}, LZB ? 8'b0000 : 8'b1000);

    // Asynchronous reset between edges while driving digit 0 with a commit pending.
    applyStimulus(1'b1, 2'd0, 4'd8, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    runTo(347);
    checkAll("pre_reset", 4'd8, 4'b0001, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkOutput("pre_reset_pending", {7'd0, commit_pending}, 8'd1);
    #3;
    reset = 1'b1;
    #1;
    checkAll("async_reset", 4'd0, 4'b0000, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    tick();
    checkAll("post_reset_blank0", 4'd0, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("post_reset_drive", {4'd0, digit_sel}, 8'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
